uart_tx_fifo: RTL

// - 8N1 UART transmitter; serial counterpart of the UART receiver on the host link.
// - Accepts bytes over a valid/ready handshake into a small FIFO.
// - Serializes each byte LSB-first: start bit, 8 data bits, stop bit.
// - Used to stream solver results back to the host.

---
 rtl/uart_tx_fifo.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO over a valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between bit 7 and the stop bit.
module uart_tx_fifo #(
   parameter int unsigned CLK_FRQ    = 100_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       axiiv,
   input  logic [7:0] axiid,
   output logic       axiir,
   output logic       axiod,
   output logic       busy
);

   localparam int unsigned CPB = CLK_FRQ / BAUD;
   localparam int unsigned CW  = $clog2(CPB + 1);
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned OW  = PW + 1;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(CPB);
   localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_e;

   // FIFO storage and bookkeeping
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [OW-1:0] occ_q, occ_d;
   logic          full, empty, push, pop;

   // Transmitter state
   state_e        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          line_q, line_d;
   logic          tick;

   assign full  = (occ_q == OCC_FULL);
   assign empty = (occ_q == '0);
   assign axiir = !rst && !full;
   assign push  = axiiv && axiir;
   assign tick  = (count_q == CNT_MAX);

   assign axiod = line_q;
   assign busy  = (state_q != IDLE) || !empty;

   always_comb begin
      wr_d  = push ? wr_q + PW'(1) : wr_q;
      rd_d  = pop  ? rd_q + PW'(1) : rd_q;
      occ_d = occ_q;
      if (push && !pop)
         occ_d = occ_q + OW'(1);
      else if (pop && !push)
         occ_d = occ_q - OW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         occ_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         occ_q <= occ_d;
      end
   end

   // Storage needs no reset: the occupancy counter alone defines validity.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_q] <= axiid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         line_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         line_q  <= line_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (!empty) state_d = START;
         START:  if (tick) state_d = DATA;
         DATA:   if (tick && bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                 end
`ifdef UART_TX_PARITY_EN
         PARITY: if (tick) state_d = STOP;
`endif
         STOP:   if (tick) state_d = empty ? IDLE : START;
         default: state_d = IDLE;
      endcase
   end

   // Each line bit is launched on the tick that ends the previous one, so the
   // serial output stays registered and every bit lasts exactly CPB cycles.
   always_comb begin
      pop     = 1'b0;
      count_d = count_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      line_d  = line_q;
      if (state_q == IDLE) begin
         if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_q];
            line_d  = 1'b0;
            count_d = CNT_ONE;
         end
      end else begin
         count_d = tick ? CNT_ONE : count_q + CNT_ONE;
         if (tick) begin
            case (state_q)
               START: begin
                  line_d = shift_q[0];
                  bit_d  = '0;
               end
               DATA: begin
                  if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     line_d = ^shift_q;
`else
                     line_d = 1'b1;
`endif
                  end else begin
                     bit_d  = bit_q + 3'd1;
                     line_d = shift_q[bit_q + 3'd1];
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: line_d = 1'b1;
`endif
               STOP: begin
                  if (!empty) begin
                     pop     = 1'b1;
                     shift_d = mem_q[rd_q];
                     line_d  = 1'b0;
                  end else begin
                     line_d = 1'b1;
                  end
               end
               default: line_d = 1'b1;
            endcase
         end
      end
   end

endmodule
